operand_stack_ctrl: RTL and testbench

//  Calculator operand-stack controller sitting directly upstream of the 16-bit data RAM
//  (512x16, write on negedge CLK while EN=1, combinational read of RAM[ADDR]).

---
 rtl/operand_stack_ctrl.sv | 250 +++++++++++++++++++++++++
 tb/tb_operand_stack_ctrl.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_stack_ctrl.sv
// -----------------------------------------------------------------------------
// operand_stack_ctrl
//   Operand-stack controller for a calculator datapath. It sits directly in
//   front of a 2**ADDR_W x DATA_W RAM that writes on the falling clock edge
//   while EN=1 and reads RAM[ADDR] combinationally. It accepts PUSH / POP /
//   PEEK / CLEAR commands over a valid/ready handshake. Each command passes
//   through IDLE -> EXEC -> RESP. The result comes back over a response
//   handshake.
//
//   Optional build macro: STACK_OVERWRITE_EN
//     defined   : PUSH on a full stack overwrites the top entry (no error)
//     undefined : PUSH on a full stack is an overflow error
//
// Ports
//   clk_i          clock, all state on the rising edge
//   rst_ni         asynchronous reset, active low
//   cmd_valid_i    command present
//   cmd_ready_o    controller idle and accepting
//   cmd_op_i       00 PUSH, 01 POP, 10 PEEK, 11 CLEAR
//   cmd_data_i     operand for PUSH
//   rsp_valid_o    response present
//   rsp_ready_i    consumer accepts response
//   rsp_data_o     popped/peeked operand, 0 for PUSH/CLEAR/error
//   rsp_err_o      overflow or underflow
//   mem_addr_o     RAM address
//   mem_en_o       RAM write enable
//   mem_wdata_o    RAM write data
//   mem_rdata_i    RAM read data (combinational)
//   depth_cnt_o    current entry count, 0..DEPTH
//   full_o         depth_cnt_o == DEPTH
//   empty_o        depth_cnt_o == 0
// -----------------------------------------------------------------------------
module operand_stack_ctrl #(
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [1:0]        cmd_op_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_err_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_en_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [ADDR_W:0]   depth_cnt_o,
  output logic              full_o,
  output logic              empty_o
);

  // The stack must fit in the RAM without wrapping.
  if (64'(BASE_ADDR) + 64'(DEPTH) > (64'd1 << ADDR_W)) begin : g_size_check
    $error("operand_stack_ctrl: BASE_ADDR + DEPTH exceeds RAM size");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    OP_PUSH  = 2'b00,
    OP_POP   = 2'b01,
    OP_PEEK  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1'b1);
  localparam logic [ADDR_W:0]   CNT_MAX  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1'b1);
`ifdef STACK_OVERWRITE_EN
  localparam logic [ADDR_W-1:0] TOP_A    = ADDR_W'(BASE_ADDR + DEPTH - 1);
`endif

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic                err_q, err_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                rsp_err_q, rsp_err_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                mem_en_q, mem_en_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [ADDR_W:0]     depth_q, depth_d;
  logic                full_s, empty_s;

  assign full_s  = (depth_q == CNT_MAX);
  assign empty_s = (depth_q == '0);

  // Next-state and next-output logic of the command FSM.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    err_d       = err_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    mem_addr_d  = mem_addr_q;
    mem_en_d    = mem_en_q;
    mem_wdata_d = mem_wdata_q;
    depth_d     = depth_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid_i && cmd_ready_q) begin
          op_d        = op_e'(cmd_op_i);
          err_d       = 1'b0;
          cmd_ready_d = 1'b0;
          mem_en_d    = 1'b0;
          state_d     = ST_EXEC;
          case (op_e'(cmd_op_i))
            OP_PUSH: begin
              if (!full_s) begin
                mem_addr_d  = BASE_A + depth_q[ADDR_W-1:0];
                mem_wdata_d = cmd_data_i;
                mem_en_d    = 1'b1;
              end else begin
`ifdef STACK_OVERWRITE_EN
                mem_addr_d  = TOP_A;
                mem_wdata_d = cmd_data_i;
                mem_en_d    = 1'b1;
`else
                err_d       = 1'b1;
`endif
              end
            end
            OP_POP, OP_PEEK: begin
              if (!empty_s) begin
                mem_addr_d = BASE_A + depth_q[ADDR_W-1:0] - ADDR_ONE;
              end else begin
                err_d = 1'b1;
              end
            end
            default: begin
              // CLEAR touches no RAM.
              err_d = 1'b0;
            end
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_EXEC: begin
        // The RAM write (if any) happened on this cycle's falling edge.
        mem_en_d    = 1'b0;
        rsp_valid_d = 1'b1;
        rsp_err_d   = err_q;
        state_d     = ST_RESP;
        if ((op_q == OP_POP || op_q == OP_PEEK) && !err_q) begin
          rsp_data_d = mem_rdata_i;
        end else begin
          rsp_data_d = '0;
        end
        case (op_q)
          OP_PUSH: begin
            // An overwrite on a full stack keeps the count at DEPTH.
            if (!err_q && !full_s) begin
              depth_d = depth_q + CNT_ONE;
            end else begin
              depth_d = depth_q;
            end
          end
          OP_POP: begin
            if (!err_q) begin
              depth_d = depth_q - CNT_ONE;
            end else begin
              depth_d = depth_q;
            end
          end
          OP_CLEAR: depth_d = '0;
          default:  depth_d = depth_q;
        endcase
      end

      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          rsp_data_d  = '0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        cmd_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_data_d  = '0;
        mem_en_d    = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_PUSH;
      err_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_addr_q  <= BASE_A;
      mem_en_q    <= 1'b0;
      mem_wdata_q <= '0;
      depth_q     <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      err_q       <= err_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_addr_q  <= mem_addr_d;
      mem_en_q    <= mem_en_d;
      mem_wdata_q <= mem_wdata_d;
      depth_q     <= depth_d;
    end
  end

  assign cmd_ready_o = cmd_ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_en_o    = mem_en_q;
  assign mem_wdata_o = mem_wdata_q;
  assign depth_cnt_o = depth_q;
  assign full_o      = full_s;
  assign empty_o     = empty_s;

endmodule

// File: tb/tb_operand_stack_ctrl.sv
// -----------------------------------------------------------------------------
// tb_operand_stack_ctrl
//   Directed scenarios plus randomized command traffic for operand_stack_ctrl.
//   The expected results come from a queue-based stack model. A behavioural
//   512x16 RAM (written on the falling edge) closes the loop.
// -----------------------------------------------------------------------------
module tb_operand_stack_ctrl;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 512;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [1:0]        cmd_op = 2'b00;
  logic [DATA_W-1:0] cmd_data = 16'h0000;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [ADDR_W:0]   depth_cnt;
  logic              full;
  logic              empty;

  logic [DATA_W-1:0] ram [DEPTH];

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model state: stack contents and last driven RAM address.
  int          model_q[$];
  logic [8:0]  model_addr = 9'd0;

  always #5 clk = ~clk;

  operand_stack_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(0)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_op_i    (cmd_op),
    .cmd_data_i  (cmd_data),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .mem_addr_o  (mem_addr),
    .mem_en_o    (mem_en),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata),
    .depth_cnt_o (depth_cnt),
    .full_o      (full),
    .empty_o     (empty)
  );

  // RAM model: write on falling edge, combinational read.
  always @(negedge clk) begin
    if (mem_en) ram[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, " depth"}, 32'(depth_cnt), 32'(model_q.size()));
    check_eq({tag, " full"},  32'(full),  32'(model_q.size() == DEPTH));
    check_eq({tag, " empty"}, 32'(empty), 32'(model_q.size() == 0));
  endtask

  // Issue one command from IDLE (called just after a falling edge) and check
  // every cycle of it against the model. hold = cycles rsp_ready stays low.
  task automatic do_cmd(input logic [1:0] op, input logic [15:0] data, input int hold);
    logic        exp_en;
    logic        exp_err;
    logic [15:0] exp_rsp;
    exp_en  = 1'b0;
    exp_err = 1'b0;
    exp_rsp = 16'h0000;
    case (op)
      2'b00: begin
        if (model_q.size() < DEPTH) begin
          exp_en     = 1'b1;
          model_addr = 9'(model_q.size());
          model_q.push_back(int'(data));
        end else begin
`ifdef STACK_OVERWRITE_EN
          exp_en     = 1'b1;
          model_addr = 9'(DEPTH - 1);
          model_q[DEPTH-1] = int'(data);
`else
          exp_err = 1'b1;
`endif
        end
      end
      2'b01, 2'b10: begin
        if (model_q.size() > 0) begin
          model_addr = 9'(model_q.size() - 1);
          exp_rsp    = 16'(model_q[model_q.size()-1]);
          if (op == 2'b01) void'(model_q.pop_back());
        end else begin
          exp_err = 1'b1;
        end
      end
      default: model_q.delete();
    endcase

    check_eq("cmd_ready idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    rsp_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    // EXEC cycle
    check_eq("exec mem_en",    32'(mem_en), 32'(exp_en));
    check_eq("exec mem_addr",  32'(mem_addr), 32'(model_addr));
    check_eq("exec cmd_ready", 32'(cmd_ready), 32'd0);
    check_eq("exec rsp_valid", 32'(rsp_valid), 32'd0);
    if (exp_en) check_eq("exec mem_wdata", 32'(mem_wdata), 32'(data));
    // Traffic while busy must be ignored.
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op    = 2'($urandom);
    cmd_data  = 16'($urandom);
    @(negedge clk);
    // RESP cycle
    check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("rsp_err",   32'(rsp_err), 32'(exp_err));
    check_eq("rsp_data",  32'(rsp_data), 32'(exp_rsp));
    check_eq("resp mem_en", 32'(mem_en), 32'd0);
    check_status("resp");
    if (exp_en) check_eq("ram content", 32'(ram[model_addr]), 32'(data));
    rsp_ready = (hold == 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("hold rsp_data",  32'(rsp_data), 32'(exp_rsp));
      check_eq("hold rsp_err",   32'(rsp_err), 32'(exp_err));
      check_eq("hold cmd_ready", 32'(cmd_ready), 32'd0);
      check_eq("hold mem_en",    32'(mem_en), 32'd0);
      if (i == hold - 1) rsp_ready = 1'b1;
    end
    @(negedge clk);
    check_eq("done rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("done rsp_data",  32'(rsp_data), 32'd0);
    check_eq("done rsp_err",   32'(rsp_err), 32'd0);
    check_eq("done cmd_ready", 32'(cmd_ready), 32'd1);
    check_status("done");
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) ram[i] = 16'h0000;

    // 1: reset, then idle
    repeat (3) @(negedge clk);
    check_eq("reset mem_en", 32'(mem_en), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("reset cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("reset rsp_err",   32'(rsp_err), 32'd0);
    check_eq("reset rsp_data",  32'(rsp_data), 32'd0);
    check_eq("reset mem_en",    32'(mem_en), 32'd0);
    check_eq("reset mem_addr",  32'(mem_addr), 32'd0);
    check_eq("reset mem_wdata", 32'(mem_wdata), 32'd0);
    check_status("reset");

    // 2: push 1234, push -5, pop, pop
    do_cmd(2'b00, 16'd1234, 0);
    do_cmd(2'b00, 16'hFFFB, 1);
    do_cmd(2'b01, 16'h0000, 0);
    do_cmd(2'b01, 16'h0000, 2);

    // 3: underflow on pop and peek
    do_cmd(2'b01, 16'h0000, 0);
    do_cmd(2'b10, 16'h0000, 0);

    // 5: peek with a long response stall
    do_cmd(2'b00, 16'd7, 0);
    do_cmd(2'b10, 16'h0000, 5);
    do_cmd(2'b11, 16'h0000, 0);

    // 4: fill the stack, then push on full
    for (int i = 0; i < DEPTH; i++) do_cmd(2'b00, 16'(i), 0);
    check_eq("full flag", 32'(full), 32'd1);
    do_cmd(2'b00, 16'h7FFF, 0);
`ifdef STACK_OVERWRITE_EN
    check_eq("ram top overwrite", 32'(ram[DEPTH-1]), 32'h7FFF);
`else
    check_eq("ram top kept", 32'(ram[DEPTH-1]), 32'(DEPTH - 1));
`endif
    do_cmd(2'b10, 16'h0000, 0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [1:0] op;
      r = $urandom_range(0, 99);
      if (r < 40)      op = 2'b00;
      else if (r < 75) op = 2'b01;
      else if (r < 95) op = 2'b10;
      else             op = 2'b11;
      do_cmd(op, 16'($urandom), $urandom_range(0, 3));
    end

    // 6: reset in the middle of a push EXEC cycle
    do_cmd(2'b11, 16'h0000, 0);
    do_cmd(2'b00, 16'd3, 0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_data  = 16'd9;
    @(negedge clk);
    check_eq("pre-reset mem_en", 32'(mem_en), 32'd1);
    cmd_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check_eq("mid reset mem_en",    32'(mem_en), 32'd0);
    check_eq("mid reset depth",     32'(depth_cnt), 32'd0);
    check_eq("mid reset cmd_ready", 32'(cmd_ready), 32'd1);
    check_eq("mid reset empty",     32'(empty), 32'd1);
    model_q.delete();
    model_addr = 9'd0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_cmd(2'b11, 16'h0000, 0);
    do_cmd(2'b01, 16'h0000, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
